// File: rtl/bsg_dmc_pkg.sv
// rtl/bsg_dmc_pkg.sv - shared DMC types: UI command codes and UI arbiter FSM states
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    eAppWrite = 3'b000,
    eAppRead  = 3'b001
  } app_cmd_e;

  typedef enum logic [1:0] {
    eIdle,
    eCmd,
    eWrData
  } bsg_dmc_ui_arb_state_e;

endpackage

// File: rtl/bsg_dmc_ui_arb_id_fifo.sv
// rtl/bsg_dmc_ui_arb_id_fifo.sv - 1r1w FIFO of requester IDs for outstanding reads
module bsg_dmc_ui_arb_id_fifo #(
  parameter int width_p = 2,
  parameter int depth_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth_p - 1);

  logic [width_p-1:0] mem_q [depth_p];
  logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ptr_w:0]     count_q, count_d;
  logic               push, pop;

  assign full_o  = (count_q == (ptr_w+1)'(depth_p));
  assign empty_o = (count_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_dmc_ui_arbiter.sv
// rtl/bsg_dmc_ui_arbiter.sv - round-robin arbiter sharing the DMC app_* UI among num_req_p clients
// Defining BSG_DMC_UI_ARBITER_PERF_EN adds saturating per-requester grant counters on grant_cnt_o.
module bsg_dmc_ui_arbiter
  import bsg_dmc_pkg::*;
#(
  parameter int num_req_p          = 4,
  parameter int ui_addr_width_p    = 28,
  parameter int ui_data_width_p    = 128,
  parameter int ui_burst_len_p     = 2,
  parameter int rd_id_fifo_depth_p = 8
) (
  input  logic                                       clk_i,
  input  logic                                       reset_n_i,
  input  logic [num_req_p-1:0]                       req_v_i,
  input  logic [num_req_p*3-1:0]                     req_cmd_i,
  input  logic [num_req_p*ui_addr_width_p-1:0]       req_addr_i,
  output logic [num_req_p-1:0]                       req_yumi_o,
  input  logic [num_req_p-1:0]                       req_wdf_v_i,
  input  logic [num_req_p*ui_data_width_p-1:0]       req_wdf_data_i,
  input  logic [num_req_p*(ui_data_width_p/8)-1:0]   req_wdf_mask_i,
  output logic [num_req_p-1:0]                       req_wdf_yumi_o,
  output logic [num_req_p-1:0]                       rd_v_o,
  output logic [ui_data_width_p-1:0]                 rd_data_o,
  output logic [ui_addr_width_p-1:0]                 app_addr_o,
  output logic [2:0]                                 app_cmd_o,
  output logic                                       app_en_o,
  input  logic                                       app_rdy_i,
  output logic                                       app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]                 app_wdf_data_o,
  output logic [ui_data_width_p/8-1:0]               app_wdf_mask_o,
  output logic                                       app_wdf_end_o,
  input  logic                                       app_wdf_rdy_i,
  input  logic                                       app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]                 app_rd_data_i,
  input  logic                                       app_rd_data_end_i,
  output logic                                       err_o
`ifdef BSG_DMC_UI_ARBITER_PERF_EN
  ,
  output logic [num_req_p*32-1:0]                    grant_cnt_o
`endif
);

  localparam int id_w   = $clog2(num_req_p);
  localparam int mask_w = ui_data_width_p / 8;
  localparam int cnt_w  = (ui_burst_len_p > 1) ? $clog2(ui_burst_len_p) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(ui_burst_len_p - 1);
  localparam logic [id_w-1:0]  last_id   = id_w'(num_req_p - 1);

  bsg_dmc_ui_arb_state_e       state_q, state_d;
  logic [id_w-1:0]             rr_ptr_q, rr_ptr_d, gnt_id_q, gnt_id_d, pick_id, fifo_head;
  app_cmd_e                    cmd_q, cmd_d;
  logic [ui_addr_width_p-1:0]  addr_q, addr_d;
  logic [cnt_w-1:0]            beat_cnt_q, beat_cnt_d;
  logic                        err_q;
  logic [num_req_p-1:0]        elig;
  logic [id_w:0]               rr_idx;
  logic                        pick_v, fifo_push, fifo_pop, fifo_full, fifo_empty;

  logic [2:0]                  cmd_a  [num_req_p];
  logic [ui_addr_width_p-1:0]  addr_a [num_req_p];
  logic [ui_data_width_p-1:0]  data_a [num_req_p];
  logic [mask_w-1:0]           mask_a [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign cmd_a[g]  = req_cmd_i[3*g +: 3];
    assign addr_a[g] = req_addr_i[ui_addr_width_p*g +: ui_addr_width_p];
    assign data_a[g] = req_wdf_data_i[ui_data_width_p*g +: ui_data_width_p];
    assign mask_a[g] = req_wdf_mask_i[mask_w*g +: mask_w];
  end

  // Reads are held back while every ID slot is taken; writes never need a slot.
  always_comb begin
    elig    = '0;
    pick_v  = 1'b0;
    pick_id = '0;
    rr_idx  = '0;
    for (int i = 0; i < num_req_p; i++)
      elig[i] = req_v_i[i] & ~(fifo_full & (cmd_a[i] == eAppRead));
    for (int k = 0; k < num_req_p; k++) begin
      rr_idx = {1'b0, rr_ptr_q} + (id_w+1)'(k);
      if (rr_idx >= (id_w+1)'(num_req_p)) rr_idx = rr_idx - (id_w+1)'(num_req_p);
      if (!pick_v && elig[rr_idx[id_w-1:0]]) begin
        pick_v  = 1'b1;
        pick_id = rr_idx[id_w-1:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_id_d       = gnt_id_q;
    cmd_d          = cmd_q;
    addr_d         = addr_q;
    beat_cnt_d     = beat_cnt_q;
    app_en_o       = 1'b0;
    req_yumi_o     = '0;
    req_wdf_yumi_o = '0;
    app_wdf_wren_o = 1'b0;
    app_wdf_end_o  = 1'b0;
    app_wdf_data_o = '0;
    app_wdf_mask_o = '0;
    fifo_push      = 1'b0;
    unique case (state_q)
      eIdle: begin
        if (pick_v) begin
          gnt_id_d = pick_id;
          cmd_d    = app_cmd_e'(cmd_a[pick_id]);
          addr_d   = addr_a[pick_id];
          state_d  = eCmd;
        end
      end
      eCmd: begin
        app_en_o = 1'b1;
        if (app_rdy_i) begin
          req_yumi_o[gnt_id_q] = 1'b1;
          rr_ptr_d = (gnt_id_q == last_id) ? '0 : gnt_id_q + 1'b1;
          if (cmd_q == eAppRead) begin
            fifo_push = 1'b1;
            state_d   = eIdle;
          end else begin
            beat_cnt_d = '0;
            state_d    = eWrData;
          end
        end
      end
      eWrData: begin
        app_wdf_wren_o = req_wdf_v_i[gnt_id_q];
        app_wdf_data_o = data_a[gnt_id_q];
        app_wdf_mask_o = mask_a[gnt_id_q];
        app_wdf_end_o  = (beat_cnt_q == last_beat);
        if (app_wdf_wren_o && app_wdf_rdy_i) begin
          req_wdf_yumi_o[gnt_id_q] = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (app_wdf_end_o) state_d = eIdle;
        end
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= eIdle;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      cmd_q      <= eAppWrite;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_q | (app_rd_data_valid_i & fifo_empty);
    end
  end

  assign app_addr_o = addr_q;
  assign app_cmd_o  = cmd_q;
  assign rd_data_o  = app_rd_data_i;
  assign err_o      = err_q;
  assign fifo_pop   = app_rd_data_valid_i & app_rd_data_end_i;

  // Read beats with no outstanding ID are dropped rather than steered.
  always_comb begin
    rd_v_o = '0;
    if (app_rd_data_valid_i && !fifo_empty) rd_v_o[fifo_head] = 1'b1;
  end

  bsg_dmc_ui_arb_id_fifo #(
    .width_p (id_w),
    .depth_p (rd_id_fifo_depth_p)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (fifo_push),
    .data_i    (gnt_id_q),
    .pop_i     (fifo_pop),
    .data_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

`ifdef BSG_DMC_UI_ARBITER_PERF_EN
  for (genvar g = 0; g < num_req_p; g++) begin : g_perf
    logic [31:0] grant_cnt_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) grant_cnt_q <= '0;
      else if (req_yumi_o[g] && grant_cnt_q != '1) grant_cnt_q <= grant_cnt_q + 32'd1;
    end
    assign grant_cnt_o[32*g +: 32] = grant_cnt_q;
  end
`endif

endmodule
